// File: rtl/scan_ctrl_pkg.sv
// Shared types and constants for the scan chain controller.
package scan_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CAPTURE,
    UNLOAD,
    DONE_S
  } state_t;

  localparam logic SE_SHIFT   = 1'b1;
  localparam logic SE_CAPTURE = 1'b0;

endpackage

// File: rtl/scan_shift_reg.sv
// Parallel-load / serial-shift register; shifts toward the MSB, serial in at the LSB.
module scan_shift_reg #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RSTB,
  input  logic             load_en,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] par_in,
  input  logic             ser_in,
  output logic [WIDTH-1:0] par_out,
  output logic             ser_out
);

  logic [WIDTH-1:0] q;

  // Parallel load takes priority over shifting.
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      q <= '0;
    end else if (load_en) begin
      q <= par_in;
    end else if (shift_en) begin
      q <= {q[WIDTH-2:0], ser_in};
    end
  end

  assign par_out = q;
  assign ser_out = q[WIDTH-1];

endmodule

// File: rtl/scan_chain_ctrl.sv
// Tester-side scan controller: serial load, one functional capture, serial unload.
module scan_chain_ctrl
  import scan_ctrl_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = 16,
  parameter int unsigned CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic                 CLK,
  input  logic                 RSTB,
  input  logic                 START,
  input  logic                 ABORT,
  input  logic [CHAIN_LEN-1:0] PAT_IN,
  input  logic                 SO,
  output logic                 SE,
  output logic                 SI,
  output logic                 BUSY,
  output logic                 DONE,
  output logic [CHAIN_LEN-1:0] RESP_OUT
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               se_d, si_d, busy_d, done_d;
  logic               pat_load, pat_shift, resp_shift, resp_upd;
  logic               pat_ser;
  logic [CHAIN_LEN-1:0] pat_par_unused;
  logic [CHAIN_LEN-1:0] resp_par;
  logic               resp_ser_unused;

  // MSB goes straight to SI on START, so the serialiser holds the remaining bits pre-shifted.
  scan_shift_reg #(.WIDTH(CHAIN_LEN)) u_pat (
    .CLK      (CLK),
    .RSTB     (RSTB),
    .load_en  (pat_load),
    .shift_en (pat_shift),
    .par_in   ({PAT_IN[CHAIN_LEN-2:0], 1'b0}),
    .ser_in   (1'b0),
    .par_out  (pat_par_unused),
    .ser_out  (pat_ser)
  );

  scan_shift_reg #(.WIDTH(CHAIN_LEN)) u_resp (
    .CLK      (CLK),
    .RSTB     (RSTB),
    .load_en  (1'b0),
    .shift_en (resp_shift),
    .par_in   ('0),
    .ser_in   (SO),
    .par_out  (resp_par),
    .ser_out  (resp_ser_unused)
  );

  // Next state plus next values of the registered chain-side outputs.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    se_d       = 1'b0;
    si_d       = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    pat_load   = 1'b0;
    pat_shift  = 1'b0;
    resp_shift = 1'b0;
    resp_upd   = 1'b0;

    if (ABORT) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (START) begin
            state_d  = LOAD;
            cnt_d    = '0;
            pat_load = 1'b1;
            se_d     = SE_SHIFT;
            si_d     = PAT_IN[CHAIN_LEN-1];
            busy_d   = 1'b1;
          end
        end
        LOAD: begin
          busy_d = 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_d = CAPTURE;
            cnt_d   = '0;
            se_d    = SE_CAPTURE;
          end else begin
            cnt_d     = cnt_q + CNT_W'(1);
            se_d      = SE_SHIFT;
            si_d      = pat_ser;
            pat_shift = 1'b1;
          end
        end
        CAPTURE: begin
          state_d    = UNLOAD;
          cnt_d      = '0;
          resp_shift = 1'b1;
          se_d       = SE_SHIFT;
          busy_d     = 1'b1;
        end
        UNLOAD: begin
          if (cnt_q == CNT_LAST) begin
            state_d  = DONE_S;
            cnt_d    = '0;
            done_d   = 1'b1;
            resp_upd = 1'b1;
          end else begin
            cnt_d      = cnt_q + CNT_W'(1);
            resp_shift = 1'b1;
            se_d       = SE_SHIFT;
            busy_d     = 1'b1;
          end
        end
        DONE_S: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      SE       <= 1'b0;
      SI       <= 1'b0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      RESP_OUT <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      SE      <= se_d;
      SI      <= si_d;
      BUSY    <= busy_d;
      DONE    <= done_d;
      if (resp_upd) begin
        RESP_OUT <= resp_par;
      end
    end
  end

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Directed bench for scan_chain_ctrl with behavioural negedge scan chains (lengths 4 and 16).
module tb_scan_chain_ctrl;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        RSTB;
  logic        start4, abort4, so4;
  logic [3:0]  pat4, resp4;
  logic        se4, si4, busy4, done4;
  logic        start16, abort16, so16;
  logic [15:0] pat16, resp16;
  logic        se16, si16, busy16, done16;

  // Chain models; mode 0: D=~Q, 1: D=0, 2: D=Q.
  logic [3:0]  chain4  = '0;
  logic [15:0] chain16 = '0;
  int          mode4   = 0;
  int          mode16  = 2;

  int n_checks = 0;
  int n_fail   = 0;

  scan_chain_ctrl #(.CHAIN_LEN(4)) dut4 (
    .CLK(CLK), .RSTB(RSTB), .START(start4), .ABORT(abort4), .PAT_IN(pat4), .SO(so4),
    .SE(se4), .SI(si4), .BUSY(busy4), .DONE(done4), .RESP_OUT(resp4)
  );

  scan_chain_ctrl #(.CHAIN_LEN(16)) dut16 (
    .CLK(CLK), .RSTB(RSTB), .START(start16), .ABORT(abort16), .PAT_IN(pat16), .SO(so16),
    .SE(se16), .SI(si16), .BUSY(busy16), .DONE(done16), .RESP_OUT(resp16)
  );

  assign so4  = chain4[3];
  assign so16 = chain16[15];

  always @(negedge CLK) begin
    if (se4) chain4 <= {chain4[2:0], si4};
    else if (mode4 == 0) chain4 <= ~chain4;
    else if (mode4 == 1) chain4 <= '0;
    if (se16) chain16 <= {chain16[14:0], si16};
    else if (mode16 == 0) chain16 <= ~chain16;
    else if (mode16 == 1) chain16 <= '0;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Leaves the bench 1 ns into LOAD cycle 0.
  task automatic start_seq4(input logic [3:0] p);
    pat4   = p;
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
  endtask

  task automatic test_reset();
    RSTB = 1'b0;
    start4 = 0; abort4 = 0; pat4 = '0;
    start16 = 0; abort16 = 0; pat16 = '0;
    #12;
    n_checks++;
    if ({se4, si4, busy4, done4, resp4} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_len4: got %b required 00000000", {se4, si4, busy4, done4, resp4});
    end
    n_checks++;
    if ({se16, si16, busy16, done16, resp16} !== 20'h0) begin
      n_fail++;
      $display("FAIL reset_len16: got %h required 00000", {se16, si16, busy16, done16, resp16});
    end
    @(posedge CLK);
    #1;
    RSTB = 1'b1;
    tick();
    n_checks++;
    if ({se4, busy4, done4} !== 3'b000) begin
      n_fail++;
      $display("FAIL idle_after_reset: got %b required 000", {se4, busy4, done4});
    end
  endtask

  task automatic test_loopback();
    logic [3:0] p;
    p = 4'b1011;
    mode4 = 0;
    start_seq4(p);
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if ({se4, si4, busy4} !== {1'b1, p[3-k], 1'b1}) begin
        n_fail++;
        $display("FAIL load_cycle%0d: se/si/busy=%b required %b", k, {se4, si4, busy4}, {1'b1, p[3-k], 1'b1});
      end
      tick();
    end
    n_checks++;
    if ({se4, si4, busy4, done4} !== 4'b0010) begin
      n_fail++;
      $display("FAIL capture_cycle: se/si/busy/done=%b required 0010", {se4, si4, busy4, done4});
    end
    for (int c = 5; c < 9; c++) begin
      tick();
      n_checks++;
      if ({se4, si4, busy4, done4} !== 4'b1010) begin
        n_fail++;
        $display("FAIL unload_cycle%0d: se/si/busy/done=%b required 1010", c, {se4, si4, busy4, done4});
      end
    end
    tick();
    n_checks++;
    if ({se4, busy4, done4, resp4} !== 7'b001_0100) begin
      n_fail++;
      $display("FAIL loopback_done: se/busy/done/resp=%b required 0010100", {se4, busy4, done4, resp4});
    end
    tick();
    n_checks++;
    if ({busy4, done4, resp4} !== 6'b00_0100) begin
      n_fail++;
      $display("FAIL loopback_after_done: busy/done/resp=%b required 000100", {busy4, done4, resp4});
    end
  endtask

  task automatic test_abort();
    mode4 = 0;
    start_seq4(4'b1011);
    for (int i = 1; i <= 7; i++) tick();
    n_checks++;
    if ({se4, busy4} !== 2'b11) begin
      n_fail++;
      $display("FAIL abort_pre_unload: se/busy=%b required 11", {se4, busy4});
    end
    abort4 = 1'b1;
    tick();
    abort4 = 1'b0;
    n_checks++;
    if ({se4, si4, busy4, done4, resp4} !== 8'b0000_0100) begin
      n_fail++;
      $display("FAIL abort_unload: se/si/busy/done/resp=%b required 00000100", {se4, si4, busy4, done4, resp4});
    end
    tick();
    n_checks++;
    if ({done4, resp4} !== 5'b0_0100) begin
      n_fail++;
      $display("FAIL abort_no_done: done/resp=%b required 00100", {done4, resp4});
    end
    pat4 = 4'b0001;
    start4 = 1'b1;
    abort4 = 1'b1;
    tick();
    start4 = 1'b0;
    abort4 = 1'b0;
    n_checks++;
    if ({se4, busy4} !== 2'b00) begin
      n_fail++;
      $display("FAIL abort_with_start: se/busy=%b required 00", {se4, busy4});
    end
    tick();
    n_checks++;
    if (busy4 !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_with_start_idle: busy=%b required 0", busy4);
    end
  endtask

  task automatic test_zero_flush();
    mode4 = 1;
    start_seq4(4'b1111);
    for (int i = 1; i <= 4; i++) tick();
    n_checks++;
    if (chain4 !== 4'b1111) begin
      n_fail++;
      $display("FAIL zero_flush_loaded_chain: got %b required 1111", chain4);
    end
    for (int i = 5; i <= 9; i++) tick();
    n_checks++;
    if ({done4, resp4, chain4} !== 9'b1_0000_0000) begin
      n_fail++;
      $display("FAIL zero_flush_done: done/resp/chain=%b required 100000000", {done4, resp4, chain4});
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int m;
    logic [3:0] exp_resp;
    mode4 = 2;
    start4 = 1'b1;
    for (int c = 0; c <= 32; c++) begin
      pat4 = 4'(c * 7 + 9);
      tick();
      m = c % 11;
      n_checks++;
      if ({busy4, done4} !== {(m != 9 && m != 10), (m == 9)}) begin
        n_fail++;
        $display("FAIL b2b_cycle%0d: busy/done=%b required %b", c, {busy4, done4}, {(m != 9 && m != 10), (m == 9)});
      end
      if (m == 9) begin
        exp_resp = 4'((c - 9) * 7 + 9);
        n_checks++;
        if (resp4 !== exp_resp) begin
          n_fail++;
          $display("FAIL b2b_resp_cycle%0d: got %b required %b", c, resp4, exp_resp);
        end
      end
    end
    start4 = 1'b0;
    tick();
    n_checks++;
    if (busy4 !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_stop: busy=%b required 0", busy4);
    end
  endtask

  task automatic test_reset_mid_load();
    mode4 = 2;
    start_seq4(4'b1110);
    tick();
    n_checks++;
    if ({se4, si4, busy4} !== 3'b111) begin
      n_fail++;
      $display("FAIL mid_load_pre: se/si/busy=%b required 111", {se4, si4, busy4});
    end
    #2;
    RSTB = 1'b0;
    #1;
    n_checks++;
    if ({se4, si4, busy4, done4, resp4} !== 8'h00) begin
      n_fail++;
      $display("FAIL mid_load_reset: se/si/busy/done/resp=%b required 00000000", {se4, si4, busy4, done4, resp4});
    end
    #3;
    RSTB = 1'b1;
    tick();
    start_seq4(4'b0110);
    for (int i = 1; i <= 9; i++) tick();
    n_checks++;
    if ({done4, resp4} !== 5'b1_0110) begin
      n_fail++;
      $display("FAIL after_reset_seq: done/resp=%b required 10110", {done4, resp4});
    end
    tick();
  endtask

  task automatic test_len16();
    logic [15:0] p;
    p = 16'($urandom);
    mode16 = 2;
    pat16 = p;
    start16 = 1'b1;
    tick();
    start16 = 1'b0;
    for (int i = 1; i <= 32; i++) tick();
    n_checks++;
    if (done16 !== 1'b0) begin
      n_fail++;
      $display("FAIL len16_early_done: done=%b required 0", done16);
    end
    tick();
    n_checks++;
    if ({done16, busy16} !== 2'b10) begin
      n_fail++;
      $display("FAIL len16_done: done/busy=%b required 10", {done16, busy16});
    end
    n_checks++;
    if (resp16 !== p) begin
      n_fail++;
      $display("FAIL len16_resp: got %h required %h", resp16, p);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_abort();
    test_zero_flush();
    test_back_to_back();
    test_reset_mid_load();
    test_len16();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
